// File: rtl/moore_seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module  : moore_seq_det_pkg
// Brief   : Shared types, legal-range constants and helpers for the
//           parametrised Moore serial-pattern detector.
// Revision: 1.0 - initial release
// ============================================================================
package moore_seq_det_pkg;

  // Detection mode, taken from the overlap input on every consume cycle.
  typedef enum logic {
    DET_NONOVL = 1'b0,
    DET_OVL    = 1'b1
  } det_mode_e;

  // Legal range for the pattern length.
  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 32;

  // Bits needed to hold a fill count in the range 0..pat_w.
  function automatic int unsigned fill_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // True when pat_w lies inside the supported range.
  function automatic bit pat_w_legal(input int unsigned pat_w);
    return (pat_w >= PAT_W_MIN) && (pat_w <= PAT_W_MAX);
  endfunction

endpackage : moore_seq_det_pkg
`default_nettype wire

// File: rtl/moore_seq_det_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating up-counter used for the detector match count.
//           A clear that coincides with an increment gives 1, so the
//           match on the clearing edge is not lost.
//           Built only when MOORE_SEQ_DET_COUNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`ifdef MOORE_SEQ_DET_COUNT_EN
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] C_CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over increment, increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter
`endif
`default_nettype wire

// File: rtl/moore_seq_det.sv
`default_nettype none
// ============================================================================
// Module  : moore_seq_det
// Brief   : Parametrised Moore serial-pattern detector. Matches a runtime
//           loadable PAT_W-bit pattern (MSB = oldest bit) on a qualified
//           serial stream, overlapping or non-overlapping. op is registered
//           and pulses for one cycle per match.
//           Optional saturating match counter: define MOORE_SEQ_DET_COUNT_EN.
//           Without it match_cnt is tied to 0 and cnt_clr is ignored.
// Revision: 1.0 - initial release
// ============================================================================
module moore_seq_det
  import moore_seq_det_pkg::*;
#(
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     RST_PAT = PAT_W'(4'b1001),
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ip_valid,
  input  logic             ip,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             op,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned        FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0]  C_FILL_FULL = FILL_W'(PAT_W);

  // Out-of-range pattern lengths are rejected at elaboration.
  if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
    $error("moore_seq_det: PAT_W out of range");
  end

  // State registers and their next-state values.
  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              op_q,   op_d;

  // Combinational helpers.
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              match;
  det_mode_e         mode;

  assign mode       = det_mode_e'(overlap);
  assign hist_shift = {hist_q[PAT_W-2:0], ip};
  // Fill saturates at PAT_W: once full, every further bit is a candidate.
  assign fill_inc   = (fill_q == C_FILL_FULL) ? fill_q : (fill_q + FILL_W'(1));

  // Next-state and match decode; load overrides any bit on the same cycle.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    op_d   = 1'b0;
    match  = 1'b0;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (ip_valid) begin
      hist_d = hist_shift;
      // A match needs a full window of fresh bits, not just equal history.
      match  = (hist_shift == pat_q) && (fill_inc == C_FILL_FULL);
      op_d   = match;
      if (match && (mode == DET_NONOVL)) begin
        // Restart the window so matched bits cannot seed the next match.
        fill_d = '0;
      end else begin
        fill_d = fill_inc;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= RST_PAT;
      hist_q <= '0;
      fill_q <= '0;
      op_q   <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      op_q   <= op_d;
    end
  end

  assign op = op_q;

`ifdef MOORE_SEQ_DET_COUNT_EN
  // Match counter advances on the same edge that raises op.
  sat_counter #(
    .W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (match),
    .cnt   (match_cnt)
  );
`else
  // Counter not built: output tied low, clear input intentionally unused.
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign match_cnt        = '0;
`endif

endmodule : moore_seq_det
`default_nettype wire

// File: tb/tb_moore_seq_det.sv
`default_nettype none
// ============================================================================
// Module  : tb_moore_seq_det
// Brief   : Scoreboard bench for moore_seq_det (PAT_W=4, CNT_W=2).
//           Driver pushes expected op/match_cnt per issued cycle; a monitor
//           on the falling edge pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_moore_seq_det;

`ifdef MOORE_SEQ_DET_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             reset;
  logic             ip_valid;
  logic             ip;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap;
  logic             cnt_clr;
  logic             op;
  logic [CNT_W-1:0] match_cnt;

  moore_seq_det #(
    .PAT_W   (PAT_W),
    .RST_PAT (4'b1001),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ip_valid  (ip_valid),
    .ip        (ip),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .overlap   (overlap),
    .cnt_clr   (cnt_clr),
    .op        (op),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic             op;
    logic [CNT_W-1:0] cnt;
    int               tid;
    int               idx;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  // Monitor: compare every expectation whose sampling edge has passed.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      if (op === e.op) n_pass++;
      else $display("FAIL op test%0d step%0d: got %b expected %b", e.tid, e.idx, op, e.op);
      n_checks++;
      if (match_cnt === e.cnt) n_pass++;
      else $display("FAIL match_cnt test%0d step%0d: got %0d expected %0d",
                    e.tid, e.idx, match_cnt, e.cnt);
    end
  end

  // One driven cycle; exp_op is the hand-computed op after the sampling edge.
  task automatic step(input logic v, input logic b, input logic ld,
                      input logic [PAT_W-1:0] pin, input logic ovl,
                      input logic clr, input logic exp_op,
                      input int tid, input int idx);
    exp_t e;
    @(posedge clk);
    #1;
    ip_valid = v;
    ip       = b;
    pat_load = ld;
    pat_in   = pin;
    overlap  = ovl;
    cnt_clr  = clr;
    if (!CNT_EN)                          exp_cnt = '0;
    else if (clr)                         exp_cnt = exp_op ? 2'd1 : 2'd0;
    else if (exp_op && exp_cnt != 2'd3)   exp_cnt = exp_cnt + 2'd1;
    e.cyc = cyc + 1; e.op = exp_op; e.cnt = exp_cnt; e.tid = tid; e.idx = idx;
    sb_q.push_back(e);
  endtask

  // Valid bits MSB-first from bits[n-1:0], expected op from exp[n-1:0].
  task automatic run_stream(input logic [31:0] bits, input logic [31:0] exp,
                            input int n, input logic ovl, input int tid);
    for (int i = 0; i < n; i++)
      step(1'b1, bits[n-1-i], 1'b0, '0, ovl, 1'b0, exp[n-1-i], tid, i + 1);
  endtask

  // Pulse reset low for one cycle; outputs must clear immediately.
  task automatic pulse_reset(input int tid);
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b0; ip_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    exp_cnt = '0;
    e.cyc = cyc; e.op = 1'b0; e.cnt = '0; e.tid = tid; e.idx = 0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; ip_valid = 1'b0; ip = 1'b0; pat_load = 1'b0;
    pat_in = '0; overlap = 1'b1; cnt_clr = 1'b0;
    e.cyc = 0; e.op = 1'b0; e.cnt = '0; e.tid = 0; e.idx = 0;
    sb_q.push_back(e);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // T1: reset mid-stream, then a fresh 1001 matches on its 4th bit.
    run_stream(32'b100, 32'b000, 3, 1'b1, 1);
    pulse_reset(1);
    run_stream(32'b1001, 32'b0001, 4, 1'b1, 1);

    // T2: overlapping, default pattern; matches after bits 9 and 12.
    step(1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 2, 0);
    run_stream(32'b0100010010011010100011, 32'b0000000010010000000000, 22, 1'b1, 2);

    // T3: same stream non-overlapping; only bit 9 matches.
    step(1'b0, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 3, 0);
    run_stream(32'b0100010010011010100011, 32'b0000000010000000000000, 22, 1'b0, 3);

    // T4: load 1101 alongside a qualified 1 (discarded); count 1 -> 3.
    step(1'b1, 1'b1, 1'b1, 4'b1101, 1'b1, 1'b0, 1'b0, 4, 0);
    run_stream(32'b1101101, 32'b0001001, 7, 1'b1, 4);

    // T5: 1,0,0,1 with ip_valid gaps; single pulse after the last bit.
    step(1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 5, 0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 5, 1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 5, 2);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 5, 3);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 5, 4);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 5, 5);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 5, 6);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 5, 7);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 5, 8);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 5, 9);

    // T6: five overlapping matches; 2-bit counter saturates at 3.
    step(1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 6, 0);
    run_stream(32'b1001001001001001, 32'b0001001001001001, 16, 1'b1, 6);

    // T7: clear alone, then clear together with a match gives 1.
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 7, 0);
    // Load with a qualified 1: if it were consumed, 0,0,1 would match.
    step(1'b1, 1'b1, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 7, 1);
    run_stream(32'b001, 32'b000, 3, 1'b1, 7);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 7, 5);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 7, 6);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1, 7, 7);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 7, 8);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_moore_seq_det
`default_nettype wire

// File: doc/moore_seq_det.md
# moore_seq_det

Parametrised Moore serial-pattern detector, successor to the fixed 1001 detector. Matches a runtime-loadable PAT_W-bit pattern on a qualified serial bit stream. Selectable overlapping/non-overlapping detection, with an optional saturating match counter. Sits on serial control/monitor paths, where one instance per stream replaces hand-written per-pattern FSMs.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..32.
- RST_PAT, 4'b1001: pattern loaded at reset; MSB is the oldest bit.
- CNT_W, 8: match counter width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ip_valid  in  1  qualifies ip; a bit is consumed only when ip_valid=1.
- ip  in  1  serial data bit.
- pat_load  in  1  load pat_in as the new pattern.
- pat_in  in  PAT_W  new pattern, MSB = first bit received.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- op  out  1  match flag (Moore: registered, a function of state only).
- match_cnt  out  CNT_W  number of matches since reset or clear.

## Operation
- State:
  - pat register (PAT_W bits).
  - hist shift register (PAT_W bits).
  - fill counter, 0..PAT_W.
  - op register.
  - match_cnt register.
- Reset (reset=0, asynchronous):
  - pat=RST_PAT, hist=0, fill=0.
  - op=0, match_cnt=0.
- Consume (ip_valid=1, pat_load=0):
  - hist_nx = {hist[PAT_W-2:0], ip}; fill_nx = min(fill+1, PAT_W).
  - match = (hist_nx == pat) && (fill_nx == PAT_W).
  - op <= match.
  - On match with overlap=0, fill <= 0 and hist <= hist_nx, so the matched bits cannot be reused.
  - On match with overlap=1, fill stays at PAT_W.
- Idle (ip_valid=0, pat_load=0): hist and fill hold; op <= 0.
- Load (pat_load=1):
  - pat <= pat_in; hist <= 0; fill <= 0; op <= 0.
  - The ip bit in the same cycle is discarded, even if ip_valid=1. Load takes priority.
  - match_cnt is unaffected.
- overlap is sampled every consume cycle. A mode change mid-stream takes effect at the next match.
- Counter:
  - Increments by 1 on every match.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr alone sets match_cnt to 0.
  - cnt_clr together with a match sets match_cnt to 1.

## Timing
- Latency: op is high in the clock cycle that follows the edge sampling the pattern's last bit. This is 1 cycle.
- op is high for exactly one cycle per match. Back-to-back overlapping matches can give op high on consecutive consume cycles.
- match_cnt updates on the same edge that sets op.
- A bit is not counted toward a match until PAT_W valid bits have been received since reset, load, or a non-overlap match. This holds even if hist already equals pat.

## Configuration
- MOORE_SEQ_DET_COUNT_EN defined: the counter is built as described, and cnt_clr is honoured.
- MOORE_SEQ_DET_COUNT_EN undefined:
  - No counter logic is built.
  - match_cnt is driven constant 0 and cnt_clr is ignored.
  - The port list is unchanged, so instances do not need editing.

## Structure
- Package moore_seq_det_pkg holds:
  - typedef det_mode_e {DET_NONOVL=0, DET_OVL=1}.
  - Localparams for the legal PAT_W range.
- Sub-module sat_counter (params W; ports clk, reset, clr, inc, cnt) implements the saturating match counter. It is instantiated only under MOORE_SEQ_DET_COUNT_EN.
- The match compare and fill logic stay inline.

## Test plan
- Reset mid-stream:
  - Drive 1,0,0, then pulse reset low.
  - Then drive 1 -> op=0, match_cnt=0; fill restarts from 0.
- Overlap, default pattern 1001, overlap=1:
  - Stream 0,1,0,0,0,1,0,0,1,0,0,1,1,0,1,0,1,0,0,0,1,1.
  - Required: op pulses after bits 9 and 12 (1-based), and match_cnt=2.
- Non-overlap: same stream with overlap=0 -> op pulses only after bit 9, and match_cnt=1.
- Pattern load with a qualified bit:
  - Assert pat_load with pat_in=4'b1101 while ip_valid=1 and ip=1. The bit is discarded.
  - Then stream 1,1,0,1,1,0,1 with overlap=1 -> op after bits 4 and 7, and match_cnt increases by 2.
- Gaps in ip_valid:
  - Stream 1,0,0,1 with ip_valid=0 gaps between the bits -> a single op pulse on the cycle after the final valid 1.
  - op is low during every gap.
- Counter:
  - CNT_W=2 with the macro defined: produce 5 matches -> match_cnt=3 (saturated).
  - Assert cnt_clr together with a match -> match_cnt=1.
  - Macro undefined -> match_cnt stays 0 throughout.
